// File: rtl/jk_bank_writer.sv
// jk_bank_writer
// Drives the J/K inputs of an external bank of WIDTH JK flip-flops. A request
// (write a value, or toggle a mask of bits) is turned into one cycle of J/K
// excitation, after which the bank's q feedback is watched until it reaches
// the target value or the check window of TIMEOUT cycles runs out. A single
// cycle response then reports the status and the q value that was observed.
//
// Optional feature macro: JK_DRV_RETRY_EN
//   When defined, the first timeout re-drives the bank once. The second
//   excitation is a plain write toward the stored target, worked out from
//   the q value seen at that moment. rsp_retried flags any response that
//   followed a retry. When not defined, rsp_retried is tied low.
//
// Ports:
//   clk          clock, everything on the rising edge
//   reset        synchronous active-high reset
//   req_valid    request present
//   req_ready    request can be accepted (IDLE only, low during reset)
//   req_op       0 = write req_data, 1 = toggle bits set in req_data
//   req_data     write value or toggle mask
//   q_fb         q outputs of the driven JK bank
//   j, k         registered J/K drive to the bank
//   rsp_valid    one-cycle response pulse
//   rsp_err      timeout status, qualified by rsp_valid
//   rsp_q        q_fb snapshot taken when checking ended, qualified by rsp_valid
//   rsp_retried  a retry happened, qualified by rsp_valid
module jk_bank_writer #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_retried
);

  // The timer only has to count 0..TIMEOUT-1, and it never wraps because
  // CHECK leaves as soon as it reaches the last value.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] target_q,    target_d;
  logic [TW-1:0]    timer_q,     timer_d;
  logic [WIDTH-1:0] j_q,         j_d;
  logic [WIDTH-1:0] k_q,         k_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [WIDTH-1:0] rsp_q_q,     rsp_q_d;
`ifdef JK_DRV_RETRY_EN
  logic             retried_q,     retried_d;
  logic             rsp_retried_q, rsp_retried_d;
`endif

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign j         = j_q;
  assign k         = k_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_q     = rsp_q_q;
`ifdef JK_DRV_RETRY_EN
  assign rsp_retried = rsp_retried_q;
`else
  assign rsp_retried = 1'b0;
`endif

  // Next-state logic. J/K default to 00 so the bank holds everywhere except
  // the single cycle spent in DRIVE; rsp_valid defaults low so it can only
  // ever be a one-cycle pulse.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    timer_d     = timer_q;
    j_d         = '0;
    k_d         = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_q_d     = rsp_q_q;
`ifdef JK_DRV_RETRY_EN
    retried_d     = retried_q;
    rsp_retried_d = rsp_retried_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_DRIVE;
`ifdef JK_DRV_RETRY_EN
          retried_d = 1'b0;
`endif
          if (req_op) begin
            // Toggle: 11 on every masked bit flips it whatever its value.
            target_d = q_fb ^ req_data;
            j_d      = req_data;
            k_d      = req_data;
          end else begin
            // Write: set bits that must rise, reset bits that must fall,
            // leave bits that are already right at 00.
            target_d = req_data;
            j_d      = req_data & ~q_fb;
            k_d      = ~req_data & q_fb;
          end
        end
      end

      ST_DRIVE: begin
        state_d = ST_CHECK;
        timer_d = '0;
      end

      ST_CHECK: begin
        if (q_fb == target_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_q_d     = q_fb;
`ifdef JK_DRV_RETRY_EN
          rsp_retried_d = retried_q;
`endif
        end else if (timer_q == TMAX) begin
`ifdef JK_DRV_RETRY_EN
          if (!retried_q) begin
            // A retry is always a plain write toward the stored target,
            // even for toggle requests, so that it cannot overshoot.
            state_d   = ST_DRIVE;
            retried_d = 1'b1;
            j_d       = target_q & ~q_fb;
            k_d       = ~target_q & q_fb;
          end else begin
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_q_d       = q_fb;
            rsp_retried_d = 1'b1;
          end
`else
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_q_d     = q_fb;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset aborts any request in flight without a response
  // and drops the J/K drive to hold on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      timer_q     <= '0;
      j_q         <= '0;
      k_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_q_q     <= '0;
`ifdef JK_DRV_RETRY_EN
      retried_q     <= 1'b0;
      rsp_retried_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      timer_q     <= timer_d;
      j_q         <= j_d;
      k_q         <= k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_q_q     <= rsp_q_d;
`ifdef JK_DRV_RETRY_EN
      retried_q     <= retried_d;
      rsp_retried_q <= rsp_retried_d;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_writer.sv
// tb_jk_bank_writer
// Bench for jk_bank_writer with WIDTH=4, TIMEOUT=4. An ideal JK bank model
// reacts to j/k on each rising edge; it can be frozen at 0000 to act as a
// stuck bank. Expected responses go into a scoreboard queue when a request
// is accepted and are popped when rsp_valid is seen.
module tb_jk_bank_writer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_op;
  logic [W-1:0] req_data;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         rsp_valid;
  logic         rsp_err;
  logic [W-1:0] rsp_q;
  logic         rsp_retried;

  typedef struct {
    logic         err;
    logic [W-1:0] q;
    logic         retried;
    int           acceptN;
    int           lat;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [W-1:0] qBank = '0;
  logic         stuck = 1'b0;
`ifdef JK_DRV_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  jk_bank_writer #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .q_fb(q_fb), .j(j), .k(k),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_q(rsp_q), .rsp_retried(rsp_retried)
  );

  // Clock and a cycle counter used to measure latency from the accept edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal JK bank: 00 hold, 10 set, 01 reset, 11 toggle. Frozen when stuck.
  always @(posedge clk) begin
    if (!stuck) qBank <= (j & ~qBank) | (~k & qBank);
  end
  assign q_fb = stuck ? '0 : qBank;

  // Pops one scoreboard entry against the response currently on the outputs.
  task automatic compareRsp();
    rsp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 with empty scoreboard, required none");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_err !== e.err) begin
      errors++; $display("[TB] FAIL rsp_err: got %b required %b", rsp_err, e.err);
    end
    checks++;
    if (rsp_q !== e.q) begin
      errors++; $display("[TB] FAIL rsp_q: got %b required %b", rsp_q, e.q);
    end
    checks++;
    if (rsp_retried !== e.retried) begin
      errors++; $display("[TB] FAIL rsp_retried: got %b required %b", rsp_retried, e.retried);
    end
    checks++;
    if (cyc - e.acceptN != e.lat) begin
      errors++; $display("[TB] FAIL rsp_latency: got %0d required %0d", cyc - e.acceptN, e.lat);
    end
  endtask

  // Waits for IDLE, presents one request, checks the DRIVE-cycle excitation
  // and optionally records the expected response. Returns in the DRIVE cycle.
  task automatic applyStimulus(input logic op, input logic [W-1:0] data,
                               input logic [W-1:0] expJ, input logic [W-1:0] expK,
                               input logic expErr, input logic [W-1:0] expQ,
                               input logic expRetried, input int expLat,
                               input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++; $display("[TB] FAIL wait_ready: got req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) sb.push_back('{expErr, expQ, expRetried, cyc - 1, expLat});
    @(negedge clk);
    checks++;
    if (j !== expJ || k !== expK) begin
      errors++; $display("[TB] FAIL drive_jk: got j=%b k=%b required j=%b k=%b", j, k, expJ, expK);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL drive_ready: got %b required 0", req_ready);
    end
  endtask

  // Waits (bounded) for the response of the oldest outstanding request.
  // retryLat, when nonzero, is the latency of a second DRIVE cycle whose j
  // must equal retryJ.
  task automatic awaitResponse(input int retryLat, input logic [W-1:0] retryJ);
    int aN;
    bit seen;
    seen = 1'b0;
    aN = (sb.size() > 0) ? sb[0].acceptN : cyc;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        compareRsp();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL after_rsp: got rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
        end
      end else if (retryLat != 0 && cyc - aN == retryLat) begin
        checks++;
        if (j !== retryJ) begin
          errors++; $display("[TB] FAIL retry_j: got %b required %b", j, retryJ);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_timeout: got no rsp_valid within 30 cycles, required one");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (j !== '0 || k !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got j=%b k=%b rsp_valid=%b req_ready=%b required 0000 0000 0 0",
                 j, k, rsp_valid, req_ready);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_write();
    // q=0000, write 1010.
    applyStimulus(1'b0, 4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b0, 3, 1'b1);
    awaitResponse(0, '0);
  endtask

  task automatic test_back_to_back();
    int a0;
    int seenRsp;
    seenRsp = 0;
    @(negedge clk);
    // q=1010, write 0110; a toggle with mask 0000 is held during the busy time.
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_data  = 4'b0110;
    @(posedge clk);
    #1;
    a0 = cyc - 1;
    req_op   = 1'b1;
    req_data = 4'b0000;
    sb.push_back('{1'b0, 4'b0110, 1'b0, a0, 3});
    sb.push_back('{1'b0, 4'b0110, 1'b0, a0 + 4, 3});
    for (int l = 1; l <= 8; l++) begin
      @(negedge clk);
      if (l == 1) begin
        checks++;
        if (j !== 4'b0100 || k !== 4'b1000) begin
          errors++; $display("[TB] FAIL b2b_drive1: got j=%b k=%b required j=0100 k=1000", j, k);
        end
      end
      if (l <= 3) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_busy_ready: got %b required 0 at step %0d", req_ready, l);
        end
      end
      if (l == 4) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_idle_ready: got %b required 1", req_ready);
        end
      end
      if (l == 5) begin
        req_valid = 1'b0;
        checks++;
        if (j !== 4'b0000 || k !== 4'b0000 || req_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_drive2: got j=%b k=%b req_ready=%b required 0000 0000 0", j, k, req_ready);
        end
      end
      if (rsp_valid === 1'b1) begin
        seenRsp++;
        compareRsp();
      end
    end
    req_valid = 1'b0;
    checks++;
    if (seenRsp != 2) begin
      errors++; $display("[TB] FAIL b2b_rsp_count: got %0d required 2", seenRsp);
    end
  endtask

  task automatic test_toggle();
    // q=0110, toggle 0011 -> 0101.
    applyStimulus(1'b1, 4'b0011, 4'b0011, 4'b0011, 1'b0, 4'b0101, 1'b0, 3, 1'b1);
    awaitResponse(0, '0);
    // q=0101, write the value it already holds: no excitation, still success.
    applyStimulus(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0101, 1'b0, 3, 1'b1);
    awaitResponse(0, '0);
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, RETRY,
                  RETRY ? 11 : 6, 1'b1);
    awaitResponse(RETRY ? 6 : 0, 4'b1111);
    stuck = 1'b0;
  endtask

  task automatic test_reset_abort();
    // q=0101, write 1010: j=1010 k=0101; reset lands during DRIVE.
    applyStimulus(1'b0, 4'b1010, 4'b1010, 4'b0101, 1'b0, 4'b0000, 1'b0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (j !== '0 || k !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got j=%b k=%b rsp_valid=%b req_ready=%b required 0000 0000 0 0",
               j, k, rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL abort_idle: got rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_data  = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_back_to_back();
    test_toggle();
    test_timeout();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_empty: got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_writer.md
Name: jk_bank_writer

Overview:
- Sequential driver/controller for a bank of WIDTH external JK flip-flops; it sits on the driving side of the FFs' J/K inputs.
- Accepts write or toggle requests over a valid/ready handshake.
- Converts each request to per-bit J/K excitation for one cycle, then monitors the bank's q feedback until it matches the target or a timeout expires.
- Returns a one-cycle response with the status and the observed q value.

Parameters:
WIDTH, 4, number of JK flip-flops in the driven bank (>=1)
TIMEOUT, 4, maximum CHECK cycles spent waiting for q_fb to match the target (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
req_op  input  1  0 = write req_data; 1 = toggle bits set in req_data
req_data  input  WIDTH  write value, or toggle mask
q_fb  input  WIDTH  q outputs of the driven JK bank
j  output  WIDTH  registered J drive to the bank
k  output  WIDTH  registered K drive to the bank
rsp_valid  output  1  one-cycle response pulse
rsp_err  output  1  timeout status, qualified by rsp_valid
rsp_q  output  WIDTH  q_fb snapshot, qualified by rsp_valid
rsp_retried  output  1  a retry occurred, qualified by rsp_valid; constant 0 without JK_DRV_RETRY_EN

Behaviour:
- Reset, any state, on the edge where reset=1:
  - State goes to IDLE.
  - j=0, k=0, rsp_valid=0, rsp_err=0, rsp_q=0, rsp_retried=0.
  - Stored target and timer are cleared.
  - req_ready=0 while reset is high.
- States: IDLE, DRIVE, CHECK, RESP.
- IDLE:
  - req_ready=1; j=k=0.
  - Accept on the edge where req_valid=1 and req_ready=1 (cycle n). Capture the target:
    - op0: target = req_data.
    - op1: target = q_fb ^ req_data.
  - On the same edge, register the excitation:
    - op0: j = req_data & ~q_fb, k = ~req_data & q_fb. Bits already correct get 00 (hold).
    - op1: j = k = req_data (toggle).
  - Go to DRIVE.
- DRIVE:
  - Lasts exactly 1 cycle (cycle n+1); j/k hold their registered excitation.
  - req_ready=0. Go to CHECK; timer=0; j=k=0 from the next edge.
- CHECK:
  - j=k=0; req_ready=0.
  - Each cycle compare q_fb to target.
    - Match: go to RESP with err=0.
    - No match and timer==TIMEOUT-1: go to RESP with err=1.
    - Otherwise: timer+1.
  - Occupies at most TIMEOUT cycles.
- RESP:
  - rsp_valid=1 for exactly 1 cycle.
  - rsp_q = q_fb sampled on the CHECK exit edge; rsp_err as decided in CHECK.
  - Go to IDLE; req_ready=1 in the following cycle.
- Latency:
  - With an ideal bank (q updates on the DRIVE edge), rsp_valid is high in cycle n+3.
  - Worst case without retry: rsp_valid in cycle n+2+TIMEOUT.
- Boundaries:
  - req_valid while busy: ignored, not queued; the requester must hold until ready.
  - op0 with q_fb already equal to req_data: j=k=0 during DRIVE; success in n+3.
  - op1 with mask 0: same as above.
  - req_data bits beyond WIDTH do not exist; no width extension is performed.
  - Reset mid-operation (DRIVE/CHECK/RESP): abort. No rsp_valid is produced. j=k=0 from the reset edge.
  - Timer width is clog2(TIMEOUT), minimum 1 bit; the counter never wraps because it exits at TIMEOUT-1.

Optional Feature:
- Macro: JK_DRV_RETRY_EN.
- Defined:
  - On the first timeout, instead of RESP, re-enter DRIVE once.
  - Excitation is recomputed as op0 toward the stored target from the current q_fb (applies to toggle requests too).
  - Timer restarts. A second timeout produces RESP with err=1.
  - rsp_retried=1 in any response that followed a retry (success or error).
- Not defined:
  - First timeout goes directly to RESP err=1.
  - rsp_retried is tied 0.

Test Plan (WIDTH=4, TIMEOUT=4, ideal JK bank model unless noted):
1. Hold reset 2 cycles mid-stream -> j=k=0000, rsp_valid=0, req_ready=0 during reset; req_ready=1 the first cycle after release.
2. q=0000, op0 data=1010 accepted at n -> cycle n+1 j=1010 k=0000; n+3 rsp_valid=1, rsp_err=0, rsp_q=1010; then q=1010.
3. q=1010, op0 data=0110 -> j=0100 k=1000 in DRIVE; rsp_q=0110, err=0 at n+3. Second req_valid held during busy is accepted only after RESP.
4. q=0110, op1 mask=0011 -> j=k=0011 in DRIVE; rsp_q=0101, err=0 at n+3. Mask 0000 -> j=k=0000, rsp_q=0110.
5. Stuck bank (q_fb forced 0000), op0 data=1111 -> without macro: rsp_valid at n+6, err=1, rsp_q=0000. With JK_DRV_RETRY_EN: second DRIVE at n+6 with j=1111; rsp_valid at n+11, err=1, rsp_retried=1.
6. Reset asserted during DRIVE of an op0 request -> j=k=0000 from that edge; no rsp_valid pulse; IDLE with req_ready=1 after release.
